// File: rtl/spi_rdid_slave.sv
// SPI mode-0 responder emulating the RDID path of an M25P16-style flash.
// Optional RDSR (opcode 8'h05) support is enabled by defining SPI_SLAVE_RDSR_EN.
module spi_rdid_slave #(
  parameter logic [23:0] JEDEC_ID   = 24'h202015,
  parameter logic [7:0]  CMD_RDID   = 8'h9F,
  parameter bit          AUTO_REARM = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  input  logic       SPISS_N,
`ifdef SPI_SLAVE_RDSR_EN
  input  logic [7:0] status_in,
`endif
  output logic       SPIMISO,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy
);

`ifdef SPI_SLAVE_RDSR_EN
  localparam logic [7:0] CMD_RDSR = 8'h05;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RESP,
    S_RESP_SR,
    S_DONE,
    S_IGNORE
  } state_t;

  state_t      state_q;
  logic [1:0]  sclk_q;
  logic        sclk_prev_q;
  logic [1:0]  mosi_q;
  logic [1:0]  ss_n_q;
  logic [6:0]  cmd_sr_q;
  logic [23:0] id_sr_q;
  logic [4:0]  bit_cnt_q;
  logic        miso_q;
  logic        cmd_valid_q;
  logic [7:0]  cmd_byte_q;

  logic        sclk_s, mosi_s, ss_n_s;
  logic        rise, fall;
  logic [7:0]  cmd_d;
  logic [4:0]  resp_len;

  assign sclk_s = sclk_q[1];
  assign mosi_s = mosi_q[1];
  assign ss_n_s = ss_n_q[1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;
  assign cmd_d  = {cmd_sr_q, mosi_s};
  // Status responses are one byte long; the ID response is three.
  assign resp_len = (state_q == S_RESP_SR) ? 5'd8 : 5'd24;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q      <= 2'b00;
      sclk_prev_q <= 1'b0;
      mosi_q      <= 2'b00;
      ss_n_q      <= 2'b11;
      state_q     <= S_IDLE;
      cmd_sr_q    <= 7'h00;
      id_sr_q     <= 24'h000000;
      bit_cnt_q   <= 5'd0;
      miso_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
    end else begin
      sclk_q      <= {sclk_q[0], SPICLK};
      sclk_prev_q <= sclk_s;
      mosi_q      <= {mosi_q[0], SPIMOSI};
      ss_n_q      <= {ss_n_q[0], SPISS_N};
      cmd_valid_q <= 1'b0;

      // Deselect has priority over any SPICLK edge seen in the same clk.
      if (ss_n_s) begin
        state_q   <= S_IDLE;
        miso_q    <= 1'b0;
        bit_cnt_q <= 5'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_CMD;
            bit_cnt_q <= 5'd0;
          end

          S_CMD: begin
            if (rise) begin
              cmd_sr_q <= cmd_d[6:0];
              if (bit_cnt_q == 5'd7) begin
                cmd_byte_q  <= cmd_d;
                cmd_valid_q <= 1'b1;
                bit_cnt_q   <= 5'd0;
                if (cmd_d == CMD_RDID) begin
                  state_q <= S_RESP;
                  id_sr_q <= JEDEC_ID;
                end
`ifdef SPI_SLAVE_RDSR_EN
                else if (cmd_d == CMD_RDSR) begin
                  state_q <= S_RESP_SR;
                  id_sr_q <= {status_in, 16'h0000};
                end
`endif
                else begin
                  state_q <= S_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end

          S_RESP, S_RESP_SR: begin
            if (fall && (bit_cnt_q != resp_len)) begin
              miso_q    <= id_sr_q[23];
              id_sr_q   <= {id_sr_q[22:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else if (rise && (bit_cnt_q == resp_len)) begin
              // Master has sampled the last bit on this rise.
              miso_q    <= 1'b0;
              bit_cnt_q <= 5'd0;
              state_q   <= AUTO_REARM ? S_CMD : S_DONE;
            end
          end

          default: begin
            miso_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SPIMISO   = miso_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_rdid_slave.sv
// Directed bench for spi_rdid_slave: one default instance driven with SS_N, one
// AUTO_REARM instance with SS_N tied low sharing SPICLK/SPIMOSI.
module tb_spi_rdid_slave;
  logic       clk = 1'b0;
  logic       reset;
  logic       SPICLK;
  logic       SPIMOSI;
  logic       SPISS_N;
  logic       miso1, cv1, busy1;
  logic [7:0] cb1;
  logic       miso2, cv2, busy2;
  logic [7:0] cb2;
`ifdef SPI_SLAVE_RDSR_EN
  logic [7:0] status_in = 8'hA5;
`endif

  int nchk = 0;
  int nerr = 0;
  int cvn1 = 0;
  int cvn2 = 0;

  always #5 clk = ~clk;

  spi_rdid_slave u_dut (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPISS_N(SPISS_N),
`ifdef SPI_SLAVE_RDSR_EN
    .status_in(status_in),
`endif
    .SPIMISO(miso1), .cmd_valid(cv1), .cmd_byte(cb1), .busy(busy1)
  );

  spi_rdid_slave #(.AUTO_REARM(1'b1)) u_dut_rearm (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPISS_N(1'b0),
`ifdef SPI_SLAVE_RDSR_EN
    .status_in(status_in),
`endif
    .SPIMISO(miso2), .cmd_valid(cv2), .cmd_byte(cb2), .busy(busy2)
  );

  always @(posedge clk) begin
    if (cv1 === 1'b1) cvn1++;
    if (cv2 === 1'b1) cvn2++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SPI mode-0 transfer of nbits, MSB first; MISO sampled just before each rise.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit sel,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SPIMOSI = tx[7-i];
      wclk(4);
      rx = {rx[6:0], (sel ? miso2 : miso1)};
      SPICLK = 1'b1;
      wclk(4);
      SPICLK = 1'b0;
    end
  endtask

  task automatic start_frame;
    SPISS_N = 1'b1;
    wclk(4);
    SPISS_N = 1'b0;
    wclk(4);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int c0;
    reset   = 1'b1;
    SPICLK  = 1'b0;
    SPIMOSI = 1'b0;
    SPISS_N = 1'b1;
    wclk(3);
    chk("rst_miso",   miso1, 0);
    chk("rst_busy",   busy1, 0);
    chk("rst_cmdbyte", cb1, 8'h00);
    chk("rst_cmdvld", cv1, 0);
    chk("rst_busy2",  busy2, 0);
    reset = 1'b0;
    wclk(2);

    // RDID
    c0 = cvn1;
    start_frame();
    xfer(8'h9F, 8, 0, rx);
    xfer(8'h00, 8, 0, rx);
    chk("rdid_b0", rx, 8'h20);
    chk("rdid_cmdbyte", cb1, 8'h9F);
    chk("rdid_cvcnt", cvn1 - c0, 1);
    chk("rdid_busy0", busy1, 1);
    xfer(8'h00, 8, 0, rx);
    chk("rdid_b1", rx, 8'h20);
    chk("rdid_busy1", busy1, 1);
    xfer(8'h00, 8, 0, rx);
    chk("rdid_b2", rx, 8'h15);
    chk("rdid_busy2", busy1, 1);
    xfer(8'h00, 8, 0, rx);
    chk("done_miso", rx, 8'h00);
    chk("done_busy", busy1, 1);
    chk("rdid_cvcnt_end", cvn1 - c0, 1);

    // Unknown opcode
    c0 = cvn1;
    start_frame();
    xfer(8'h03, 8, 0, rx);
    chk("unk_cmdbyte", cb1, 8'h03);
    for (int k = 0; k < 3; k++) begin
      xfer(8'h00, 8, 0, rx);
      chk("unk_miso", rx, 8'h00);
    end
    chk("unk_busy", busy1, 1);
    chk("unk_cvcnt", cvn1 - c0, 1);

    // Abort after 4 command bits
    c0 = cvn1;
    start_frame();
    xfer(8'h9F, 4, 0, rx);
    SPISS_N = 1'b1;
    wclk(3);
    chk("abort_busy", busy1, 0);
    chk("abort_cvcnt", cvn1 - c0, 0);
    chk("abort_cmdbyte", cb1, 8'h03);
    start_frame();
    xfer(8'h9F, 8, 0, rx);
    xfer(8'h00, 8, 0, rx);
    chk("abort_b0", rx, 8'h20);
    xfer(8'h00, 8, 0, rx);
    chk("abort_b1", rx, 8'h20);
    xfer(8'h00, 8, 0, rx);
    chk("abort_b2", rx, 8'h15);

    // Reset while ID bit 10 (a '1') is on MISO
    start_frame();
    xfer(8'h9F, 8, 0, rx);
    xfer(8'h00, 8, 0, rx);
    xfer(8'h00, 2, 0, rx);
    chk("pre_rst_bits", rx[1:0], 2'b00);
    wclk(4);
    chk("pre_rst_miso", miso1, 1);
    chk("pre_rst_cmdbyte", cb1, 8'h9F);
    reset = 1'b1;
    wclk(1);
    chk("midrst_miso", miso1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_cmdbyte", cb1, 8'h00);
    SPISS_N = 1'b1;
    reset = 1'b0;
    wclk(6);

    // AUTO_REARM with SS_N tied low: back-to-back frames
    c0 = cvn2;
    for (int f = 0; f < 2; f++) begin
      xfer(8'h9F, 8, 1, rx);
      xfer(8'h00, 8, 1, rx);
      chk("rearm_b0", rx, 8'h20);
      xfer(8'h00, 8, 1, rx);
      chk("rearm_b1", rx, 8'h20);
      xfer(8'h00, 8, 1, rx);
      chk("rearm_b2", rx, 8'h15);
    end
    chk("rearm_cvcnt", cvn2 - c0, 2);
    chk("rearm_cmdbyte", cb2, 8'h9F);
    chk("rearm_busy", busy2, 1);

    // Status read
    start_frame();
    xfer(8'h05, 8, 0, rx);
    chk("rdsr_cmdbyte", cb1, 8'h05);
    xfer(8'h00, 8, 0, rx);
`ifdef SPI_SLAVE_RDSR_EN
    chk("rdsr_status", rx, 8'hA5);
    xfer(8'h00, 8, 0, rx);
    chk("rdsr_after", rx, 8'h00);
`else
    chk("rdsr_ignored", rx, 8'h00);
`endif
    chk("rdsr_busy", busy1, 1);
    SPISS_N = 1'b1;
    wclk(4);
    chk("end_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
